// File: rtl/forwarder_mcast.sv
// forwarder_mcast: per-ingress-port multicast forwarder.
// Captures the frame header into a lookup key, issues one flow lookup,
// then replicates the frame to every TX FIFO (and optionally the NIC)
// selected by the returned mask. Misses are punted to the NIC; empty
// masks and lookup timeouts drop the frame and are counted.
module forwarder_mcast #(
  parameter int NPORT     = 4,
  parameter int PORT_NUM  = 0,
  parameter int HDR_LEN   = 30,
  parameter int LOOKUP_TO = 255
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [8:0]              rx_dout,
  input  logic                    rx_empty,
  output logic                    rx_rd_en,
  output logic [9*NPORT-1:0]      tx_din,
  input  logic [NPORT-1:0]        tx_full,
  output logic [NPORT-1:0]        tx_wr_en,
  output logic [8:0]              nic_din,
  input  logic                    nic_full,
  output logic                    nic_wr_en,
  output logic                    of_lookup_req,
  output logic [4+8*HDR_LEN-1:0]  of_lookup_data,
  input  logic                    of_lookup_ack,
  input  logic                    of_lookup_err,
  input  logic [NPORT:0]          of_lookup_fwd_mask,
  output logic [31:0]             stat_fwd,
  output logic [31:0]             stat_drop
);

  localparam int CNT_W = $clog2(HDR_LEN + 1);
  localparam int IDX_W = (HDR_LEN > 1) ? $clog2(HDR_LEN) : 1;
  localparam int TMR_W = (LOOKUP_TO > 1) ? $clog2(LOOKUP_TO + 1) : 1;

  localparam logic [NPORT:0] SELF_BIT = (NPORT+1)'(1) << PORT_NUM;
  localparam logic [NPORT:0] NIC_BIT  = (NPORT+1)'(1) << NPORT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOOKUP,
    S_REPLAY,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   hdr_cnt_reg;
  logic [CNT_W-1:0]   rd_ptr_reg;
  logic [TMR_W-1:0]   timer_reg;
  logic               short_reg;
  logic [NPORT:0]     mask_reg;
  logic [3:0]         port_tag_reg;
  logic [7:0]         key_reg [HDR_LEN];
  logic [31:0]        stat_fwd_reg;
  logic [31:0]        stat_drop_reg;

  logic [NPORT:0]     full_vec;
  logic               stall;
  logic [NPORT:0]     lk_mask;
  logic               lk_answer;
  logic               lk_timeout;
  logic               replay_last;
  logic [7:0]         replay_byte;

  // Output stall: any selected destination being full freezes the whole
  // replication so every destination sees the same byte sequence.
  assign full_vec    = {nic_full, tx_full};
  assign stall       = |(mask_reg & full_vec);

  // Lookup result: a miss overrides a hit and is punted to the NIC only;
  // the ingress port is never a destination.
  assign lk_answer   = of_lookup_ack | of_lookup_err;
  assign lk_mask     = of_lookup_err ? NIC_BIT : (of_lookup_fwd_mask & ~SELF_BIT);
  assign lk_timeout  = (timer_reg == TMR_W'(LOOKUP_TO - 1));

  assign replay_last = (rd_ptr_reg == hdr_cnt_reg - CNT_W'(1));
  assign replay_byte = key_reg[rd_ptr_reg[IDX_W-1:0]];

  // FWFT pop: the byte on rx_dout is consumed in the same cycle rx_rd_en is high.
  always_comb begin
    rx_rd_en = 1'b0;
    case (state_reg)
      S_HDR:    rx_rd_en = !rx_empty;
      S_STREAM: rx_rd_en = !rx_empty && !stall;
      S_DRAIN:  rx_rd_en = !rx_empty;
      default:  rx_rd_en = 1'b0;
    endcase
  end

  // Key layout: port tag in the top nibble, header byte 0 as the most significant byte.
  assign of_lookup_data[8*HDR_LEN +: 4] = port_tag_reg;
  generate
    for (genvar gi = 0; gi < HDR_LEN; gi++) begin : g_key
      assign of_lookup_data[8*(HDR_LEN-1-gi) +: 8] = key_reg[gi];
    end
  endgenerate

  assign stat_fwd  = stat_fwd_reg;
  assign stat_drop = stat_drop_reg;

  // Frame FSM with registered write strobes, output data and statistics.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_reg     <= S_IDLE;
      hdr_cnt_reg   <= '0;
      rd_ptr_reg    <= '0;
      timer_reg     <= '0;
      short_reg     <= 1'b0;
      mask_reg      <= '0;
      port_tag_reg  <= '0;
      stat_fwd_reg  <= '0;
      stat_drop_reg <= '0;
      of_lookup_req <= 1'b0;
      tx_din        <= '0;
      tx_wr_en      <= '0;
      nic_din       <= '0;
      nic_wr_en     <= 1'b0;
      for (int i = 0; i < HDR_LEN; i++) key_reg[i] <= '0;
    end else begin
      tx_wr_en  <= '0;
      nic_wr_en <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (!rx_empty) begin
            state_reg    <= S_HDR;
            hdr_cnt_reg  <= '0;
            port_tag_reg <= 4'(PORT_NUM);
            for (int i = 0; i < HDR_LEN; i++) key_reg[i] <= '0;
          end
        end
        S_HDR: begin
          if (!rx_empty) begin
            key_reg[hdr_cnt_reg[IDX_W-1:0]] <= rx_dout[7:0];
            hdr_cnt_reg <= hdr_cnt_reg + CNT_W'(1);
            if (rx_dout[8] || hdr_cnt_reg == CNT_W'(HDR_LEN - 1)) begin
              state_reg     <= S_LOOKUP;
              short_reg     <= rx_dout[8];
              of_lookup_req <= 1'b1;
              timer_reg     <= '0;
            end
          end
        end
        S_LOOKUP: begin
          if (lk_answer || lk_timeout) begin
            of_lookup_req <= 1'b0;
            if (lk_answer && lk_mask != '0) begin
              mask_reg   <= lk_mask;
              rd_ptr_reg <= '0;
              state_reg  <= S_REPLAY;
            end else begin
              stat_drop_reg <= stat_drop_reg + 32'd1;
              state_reg     <= short_reg ? S_IDLE : S_DRAIN;
            end
          end else begin
            timer_reg <= timer_reg + TMR_W'(1);
          end
        end
        S_REPLAY: begin
          if (!stall) begin
            tx_din     <= {NPORT{short_reg && replay_last, replay_byte}};
            nic_din    <= {short_reg && replay_last, replay_byte};
            tx_wr_en   <= mask_reg[NPORT-1:0];
            nic_wr_en  <= mask_reg[NPORT];
            rd_ptr_reg <= rd_ptr_reg + CNT_W'(1);
            if (replay_last) begin
              state_reg <= short_reg ? S_IDLE : S_STREAM;
              if (short_reg) stat_fwd_reg <= stat_fwd_reg + 32'd1;
            end
          end
        end
        S_STREAM: begin
          if (!rx_empty && !stall) begin
            tx_din    <= {NPORT{rx_dout}};
            nic_din   <= rx_dout;
            tx_wr_en  <= mask_reg[NPORT-1:0];
            nic_wr_en <= mask_reg[NPORT];
            if (rx_dout[8]) begin
              state_reg    <= S_IDLE;
              stat_fwd_reg <= stat_fwd_reg + 32'd1;
            end
          end
        end
        S_DRAIN: begin
          if (!rx_empty && rx_dout[8]) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_forwarder_mcast.sv
// Directed testbench for forwarder_mcast (NPORT=4, PORT_NUM=0, HDR_LEN=30, LOOKUP_TO=255).
module tb_forwarder_mcast;

  localparam int NPORT   = 4;
  localparam int HDR_LEN = 30;
  localparam int KW      = 4 + 8*HDR_LEN;

  logic               sys_clk = 1'b0;
  logic               sys_rst = 1'b0;
  logic [8:0]         rx_dout;
  logic               rx_empty;
  logic               rx_rd_en;
  logic [9*NPORT-1:0] tx_din;
  logic [NPORT-1:0]   tx_full = '0;
  logic [NPORT-1:0]   tx_wr_en;
  logic [8:0]         nic_din;
  logic               nic_full = 1'b0;
  logic               nic_wr_en;
  logic               of_lookup_req;
  logic [KW-1:0]      of_lookup_data;
  logic               of_lookup_ack = 1'b0;
  logic               of_lookup_err = 1'b0;
  logic [NPORT:0]     of_lookup_fwd_mask = '0;
  logic [31:0]        stat_fwd;
  logic [31:0]        stat_drop;

  int checks = 0;
  int errors = 0;

  forwarder_mcast #(
    .NPORT(NPORT), .PORT_NUM(0), .HDR_LEN(HDR_LEN), .LOOKUP_TO(255)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .rx_dout(rx_dout), .rx_empty(rx_empty), .rx_rd_en(rx_rd_en),
    .tx_din(tx_din), .tx_full(tx_full), .tx_wr_en(tx_wr_en),
    .nic_din(nic_din), .nic_full(nic_full), .nic_wr_en(nic_wr_en),
    .of_lookup_req(of_lookup_req), .of_lookup_data(of_lookup_data),
    .of_lookup_ack(of_lookup_ack), .of_lookup_err(of_lookup_err),
    .of_lookup_fwd_mask(of_lookup_fwd_mask),
    .stat_fwd(stat_fwd), .stat_drop(stat_drop)
  );

  always #4 sys_clk = ~sys_clk;

  // FWFT RX FIFO model; flushed by the same reset as the DUT
  logic [8:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign rx_dout  = mem[rd_ptr & 255];
  assign rx_empty = (rd_ptr == wr_ptr);

  always @(posedge sys_clk) begin
    if (!sys_rst) rd_ptr <= wr_ptr;
    else if (rx_rd_en && !rx_empty) rd_ptr <= rd_ptr + 1;
  end

  // Output capture: lanes 0..3 are TX ports, lane 4 is the NIC
  logic [8:0] cap [0:NPORT][0:1023];
  int cnt [0:NPORT];
  initial for (int i = 0; i <= NPORT; i++) cnt[i] = 0;

  always @(negedge sys_clk) begin
    for (int p = 0; p < NPORT; p++)
      if (tx_wr_en[p]) begin
        cap[p][cnt[p] & 1023] <= tx_din[9*p +: 9];
        cnt[p] <= cnt[p] + 1;
      end
    if (nic_wr_en) begin
      cap[NPORT][cnt[NPORT] & 1023] <= nic_din;
      cnt[NPORT] <= cnt[NPORT] + 1;
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int len, input int seed);
    for (int i = 0; i < len; i++) begin
      mem[wr_ptr & 255] = {(i == len-1), 8'((seed + i) & 255)};
      wr_ptr = wr_ptr + 1;
    end
  endtask

  function automatic logic [KW-1:0] exp_key(input int len, input int seed);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < HDR_LEN; i++)
      if (i < len) k[8*(HDR_LEN-1-i) +: 8] = 8'((seed + i) & 255);
    return k;
  endfunction

  // Wait for the request, check the key, then answer after lat cycles
  task automatic answer(input string tag, input logic [KW-1:0] key, input int lat,
                        input logic a, input logic e, input logic [NPORT:0] m);
    int n;
    n = 0;
    while (!of_lookup_req && n < 300) begin @(negedge sys_clk); n++; end
    check({tag, "_req"}, 256'(of_lookup_req), 256'(1));
    check({tag, "_key"}, 256'(of_lookup_data), 256'(key));
    repeat (lat) @(negedge sys_clk);
    of_lookup_ack = a; of_lookup_err = e; of_lookup_fwd_mask = m;
    @(negedge sys_clk);
    of_lookup_ack = 1'b0; of_lookup_err = 1'b0; of_lookup_fwd_mask = '0;
  endtask

  task automatic wait_cnt(input string tag, input int lane, input int target);
    int n;
    n = 0;
    while (cnt[lane] < target && n < 500) begin @(negedge sys_clk); n++; end
    check({tag, "_done"}, 256'(cnt[lane] >= target), 256'(1));
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic wait_drained(input string tag);
    int n;
    n = 0;
    while (!rx_empty && n < 500) begin @(negedge sys_clk); n++; end
    check({tag, "_drained"}, 256'(rx_empty), 256'(1));
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic check_frame(input string tag, input int lane, input int base,
                             input int len, input int seed);
    check({tag, "_len"}, 256'(cnt[lane] - base), 256'(len));
    for (int i = 0; i < len; i++)
      check({tag, "_byte"}, 256'(cap[lane][(base + i) & 1023]),
            256'({(i == len-1), 8'((seed + i) & 255)}));
  endtask

  initial begin
    int b [0:NPORT];
    int n;

    // Reset
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("rst_rd_en", 256'(rx_rd_en), 256'(0));
    check("rst_tx_wr_en", 256'(tx_wr_en), 256'(0));
    check("rst_nic_wr_en", 256'(nic_wr_en), 256'(0));
    check("rst_req", 256'(of_lookup_req), 256'(0));
    check("rst_tx_din", 256'(tx_din), 256'(0));
    check("rst_nic_din", 256'(nic_din), 256'(0));
    check("rst_key", 256'(of_lookup_data), 256'(0));
    check("rst_fwd", 256'(stat_fwd), 256'(0));
    check("rst_drop", 256'(stat_drop), 256'(0));

    // 1: 64-byte frame to ports 1 and 2
    for (int i = 0; i <= NPORT; i++) b[i] = cnt[i];
    push_frame(64, 8'h10);
    answer("t1", exp_key(64, 8'h10), 3, 1'b1, 1'b0, 5'b00110);
    wait_cnt("t1", 1, b[1] + 64);
    check_frame("t1_p1", 1, b[1], 64, 8'h10);
    check_frame("t1_p2", 2, b[2], 64, 8'h10);
    check("t1_p0_none", 256'(cnt[0] - b[0]), 256'(0));
    check("t1_p3_none", 256'(cnt[3] - b[3]), 256'(0));
    check("t1_nic_none", 256'(cnt[NPORT] - b[NPORT]), 256'(0));
    check("t1_fwd", 256'(stat_fwd), 256'(1));

    // 2: mask selects only the ingress port -> drop, then a normal frame
    for (int i = 0; i <= NPORT; i++) b[i] = cnt[i];
    push_frame(40, 8'h80);
    answer("t2", exp_key(40, 8'h80), 0, 1'b1, 1'b0, 5'b00001);
    wait_drained("t2");
    check("t2_drop", 256'(stat_drop), 256'(1));
    check("t2_fwd", 256'(stat_fwd), 256'(1));
    for (int p = 0; p <= NPORT; p++)
      check("t2_no_write", 256'(cnt[p] - b[p]), 256'(0));
    push_frame(35, 8'h40);
    answer("t2b", exp_key(35, 8'h40), 1, 1'b1, 1'b0, 5'b01001);
    wait_cnt("t2b", 3, b[3] + 35);
    check_frame("t2b_p3", 3, b[3], 35, 8'h40);
    check("t2b_p1_none", 256'(cnt[1] - b[1]), 256'(0));
    check("t2b_fwd", 256'(stat_fwd), 256'(2));

    // 3: short frame, ack and err together -> err wins, NIC only
    for (int i = 0; i <= NPORT; i++) b[i] = cnt[i];
    push_frame(20, 8'hC0);
    answer("t3", exp_key(20, 8'hC0), 2, 1'b1, 1'b1, 5'b00110);
    wait_cnt("t3", NPORT, b[NPORT] + 20);
    check_frame("t3_nic", NPORT, b[NPORT], 20, 8'hC0);
    check("t3_p1_none", 256'(cnt[1] - b[1]), 256'(0));
    check("t3_p2_none", 256'(cnt[2] - b[2]), 256'(0));
    check("t3_fwd", 256'(stat_fwd), 256'(3));

    // 4: lookup never answers -> req high exactly 255 cycles, frame drained
    for (int i = 0; i <= NPORT; i++) b[i] = cnt[i];
    push_frame(50, 8'h20);
    n = 0;
    while (!of_lookup_req && n < 300) begin @(negedge sys_clk); n++; end
    n = 0;
    while (of_lookup_req && n < 1000) begin @(negedge sys_clk); n++; end
    check("t4_req_cycles", 256'(n), 256'(255));
    wait_drained("t4");
    check("t4_drop", 256'(stat_drop), 256'(2));
    for (int p = 0; p <= NPORT; p++)
      check("t4_no_write", 256'(cnt[p] - b[p]), 256'(0));

    // 5: tx_full[2] for 10 cycles mid-STREAM stalls port 1 and RX as well
    for (int i = 0; i <= NPORT; i++) b[i] = cnt[i];
    push_frame(64, 8'h55);
    answer("t5", exp_key(64, 8'h55), 0, 1'b1, 1'b0, 5'b00110);
    n = 0;
    while (cnt[1] < b[1] + 40 && n < 200) begin @(negedge sys_clk); n++; end
    check("t5_reach_stream", 256'(cnt[1] >= b[1] + 40), 256'(1));
    tx_full[2] = 1'b1;
    #1;
    check("t5_rd_stall0", 256'(rx_rd_en), 256'(0));
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      check("t5_rd_stall", 256'(rx_rd_en), 256'(0));
      check("t5_wr_stall", 256'(tx_wr_en), 256'(0));
    end
    tx_full[2] = 1'b0;
    wait_cnt("t5", 1, b[1] + 64);
    check_frame("t5_p1", 1, b[1], 64, 8'h55);
    check_frame("t5_p2", 2, b[2], 64, 8'h55);
    check("t5_fwd", 256'(stat_fwd), 256'(4));

    // 6: one-cycle reset during REPLAY, then a fresh frame to the NIC
    push_frame(40, 8'hA0);
    answer("t6", exp_key(40, 8'hA0), 0, 1'b1, 1'b0, 5'b00010);
    n = 0;
    while (!tx_wr_en[1] && n < 50) begin @(negedge sys_clk); n++; end
    check("t6_in_replay", 256'(tx_wr_en[1]), 256'(1));
    sys_rst = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b1;
    check("t6_rd_en", 256'(rx_rd_en), 256'(0));
    check("t6_tx_wr_en", 256'(tx_wr_en), 256'(0));
    check("t6_nic_wr_en", 256'(nic_wr_en), 256'(0));
    check("t6_req", 256'(of_lookup_req), 256'(0));
    check("t6_tx_din", 256'(tx_din), 256'(0));
    check("t6_nic_din", 256'(nic_din), 256'(0));
    check("t6_key", 256'(of_lookup_data), 256'(0));
    check("t6_fwd", 256'(stat_fwd), 256'(0));
    check("t6_drop", 256'(stat_drop), 256'(0));
    repeat (2) @(negedge sys_clk);
    for (int i = 0; i <= NPORT; i++) b[i] = cnt[i];
    push_frame(10, 8'h33);
    answer("t6b", exp_key(10, 8'h33), 1, 1'b1, 1'b0, 5'b10001);
    wait_cnt("t6b", NPORT, b[NPORT] + 10);
    check_frame("t6b_nic", NPORT, b[NPORT], 10, 8'h33);
    check("t6b_p0_none", 256'(cnt[0] - b[0]), 256'(0));
    check("t6b_fwd", 256'(stat_fwd), 256'(1));
    check("t6b_drop", 256'(stat_drop), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
